// File: rtl/vc_fixed_latency_mem_responder.sv
// Fixed-latency val/rdy memory responder: memory access at accept, a (p_latency-1)-stage
// delay line, then an in-order response queue. Credits cover delay line plus queue.
module vc_fixed_latency_mem_responder #(
  parameter int p_mem_sz      = 1 << 16,
  parameter int p_addr_sz     = 32,
  parameter int p_data_sz     = 32,
  parameter int p_latency     = 1,
  parameter int p_queue_depth = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_addr_sz+p_data_sz+2:0] req_msg_i,
  input  logic                           req_val_i,
  output logic                           req_rdy_o,
  output logic [p_data_sz+2:0]           resp_msg_o,
  output logic                           resp_val_o,
  input  logic                           resp_rdy_i,
  output logic [31:0]                    num_reqs_o,
  output logic [31:0]                    num_resps_o
);

  localparam int AW     = $clog2(p_mem_sz);
  localparam int NWORDS = p_mem_sz / 4;
  localparam int RW     = p_data_sz + 3;
  localparam int PW     = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
  localparam int CW     = $clog2(p_queue_depth + 1);

  logic                 req_type;
  logic [p_addr_sz-1:0] req_addr;
  logic [1:0]           req_len;
  logic [p_data_sz-1:0] req_data;
  assign {req_type, req_addr, req_len, req_data} = req_msg_i;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[p_addr_sz-1:AW];

  logic [p_data_sz-1:0] mem_q [NWORDS];
  logic [AW-3:0]        widx;
  logic [p_data_sz-1:0] rd_shift, rdata, wword;
  logic [3:0]           wbe;
  logic [RW-1:0]        acc_msg;
  logic                 acc, handoff;

  assign widx    = req_addr[AW-1:2];
  assign acc     = req_val_i && req_rdy_o;
  assign handoff = resp_val_o && resp_rdy_i;

  // Bytes that would fall past offset 3 are dropped, never wrapped.
  always_comb begin
    int o, n;
    o        = int'(req_addr[1:0]);
    n        = (req_len == 2'd0) ? 4 : int'(req_len);
    rd_shift = mem_q[widx] >> (8 * o);
    rdata    = '0;
    wword    = '0;
    wbe      = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < n) rdata[8*b +: 8] = rd_shift[8*b +: 8];
      if (b >= o && (b - o) < n) begin
        wbe[b]          = 1'b1;
        wword[8*b +: 8] = req_data[8*(b-o) +: 8];
      end
    end
    acc_msg = {req_type, req_len, req_type ? {p_data_sz{1'b0}} : rdata};
  end

  always_ff @(posedge clk) begin
    if (acc && req_type) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem_q[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  logic          push_vld;
  logic [RW-1:0] push_msg;
  logic [31:0]   dl_occ;

  if (p_latency > 1) begin : g_dl
    logic [RW-1:0]        dl_msg_q [p_latency-1];
    logic [p_latency-2:0] dl_vld_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        dl_vld_q <= '0;
        for (int i = 0; i < p_latency - 1; i++) dl_msg_q[i] <= '0;
      end else begin
        dl_vld_q[0] <= acc;
        dl_msg_q[0] <= acc_msg;
        for (int i = 1; i < p_latency - 1; i++) begin
          dl_vld_q[i] <= dl_vld_q[i-1];
          dl_msg_q[i] <= dl_msg_q[i-1];
        end
      end
    end

    assign push_vld = dl_vld_q[p_latency-2];
    assign push_msg = dl_msg_q[p_latency-2];
    assign dl_occ   = 32'($countones(dl_vld_q));
  end else begin : g_no_dl
    assign push_vld = acc;
    assign push_msg = acc_msg;
    assign dl_occ   = '0;
  end

  logic [RW-1:0] q_mem_q [p_queue_depth];
  logic [PW-1:0] q_wr_ptr_q, q_wr_ptr_d, q_rd_ptr_q, q_rd_ptr_d;
  logic [CW-1:0] q_count_q, q_count_d;
  logic [31:0]   num_reqs_q, num_resps_q, outstanding;

  always_comb begin
    q_wr_ptr_d = q_wr_ptr_q;
    q_rd_ptr_d = q_rd_ptr_q;
    q_count_d  = q_count_q;
    if (push_vld)
      q_wr_ptr_d = (q_wr_ptr_q == PW'(p_queue_depth - 1)) ? '0 : q_wr_ptr_q + PW'(1);
    if (handoff)
      q_rd_ptr_d = (q_rd_ptr_q == PW'(p_queue_depth - 1)) ? '0 : q_rd_ptr_q + PW'(1);
    if (push_vld && !handoff)      q_count_d = q_count_q + CW'(1);
    else if (!push_vld && handoff) q_count_d = q_count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_wr_ptr_q  <= '0;
      q_rd_ptr_q  <= '0;
      q_count_q   <= '0;
      num_reqs_q  <= '0;
      num_resps_q <= '0;
      for (int i = 0; i < p_queue_depth; i++) q_mem_q[i] <= '0;
    end else begin
      q_wr_ptr_q <= q_wr_ptr_d;
      q_rd_ptr_q <= q_rd_ptr_d;
      q_count_q  <= q_count_d;
      if (push_vld) q_mem_q[q_wr_ptr_q] <= push_msg;
      if (acc)      num_reqs_q  <= num_reqs_q + 32'd1;
      if (handoff)  num_resps_q <= num_resps_q + 32'd1;
    end
  end

  // A slot freed by this cycle's handoff may be reused by this cycle's accept.
  assign outstanding = dl_occ + 32'(q_count_q);
  assign req_rdy_o   = reset && ((outstanding < 32'(p_queue_depth)) ||
                                 ((outstanding == 32'(p_queue_depth)) && handoff));
  assign resp_val_o  = reset && (q_count_q != '0);
  assign resp_msg_o  = reset ? q_mem_q[q_rd_ptr_q] : '0;
  assign num_reqs_o  = num_reqs_q;
  assign num_resps_o = num_resps_q;

endmodule

// File: tb/tb_vc_fixed_latency_mem_responder.sv
// Directed bench: one responder at latency 1 / depth 2, a second at latency 3 / depth 3.
module tb_vc_fixed_latency_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [66:0] req_msg, req_msg3;
  logic        req_val, req_rdy, req_val3, req_rdy3;
  logic [34:0] resp_msg, resp_msg3;
  logic        resp_val, resp_rdy, resp_val3, resp_rdy3;
  logic [31:0] num_reqs, num_resps, num_reqs3, num_resps3;

  vc_fixed_latency_mem_responder #(.p_latency(1), .p_queue_depth(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_msg_i(req_msg), .req_val_i(req_val), .req_rdy_o(req_rdy),
    .resp_msg_o(resp_msg), .resp_val_o(resp_val), .resp_rdy_i(resp_rdy),
    .num_reqs_o(num_reqs), .num_resps_o(num_resps)
  );

  vc_fixed_latency_mem_responder #(.p_latency(3), .p_queue_depth(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_msg_i(req_msg3), .req_val_i(req_val3), .req_rdy_o(req_rdy3),
    .resp_msg_o(resp_msg3), .resp_val_o(resp_val3), .resp_rdy_i(resp_rdy3),
    .num_reqs_o(num_reqs3), .num_resps_o(num_resps3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  function automatic logic [66:0] rq(input bit t, input logic [31:0] a, input logic [1:0] l,
                                     input logic [31:0] d);
    return {t, a, l, d};
  endfunction

  function automatic logic [34:0] rs(input bit t, input logic [1:0] l, input logic [31:0] d);
    return {t, l, d};
  endfunction

  localparam int N1 = 13;
  logic [66:0] tq1 [N1];
  logic [34:0] te1 [N1];
  logic [34:0] te4 [4];
  localparam int N5 = 7;
  logic [66:0] tq5 [N5];
  logic [34:0] te5 [N5];
  int          acc_c [N5];

  initial begin
    tq1[0]  = rq(1, 32'h100, 0, 32'hDEADBEEF); te1[0]  = rs(1, 0, 0);
    tq1[1]  = rq(0, 32'h100, 0, 0);            te1[1]  = rs(0, 0, 32'hDEADBEEF);
    tq1[2]  = rq(1, 32'h101, 1, 32'h55);       te1[2]  = rs(1, 1, 0);
    tq1[3]  = rq(0, 32'h100, 0, 0);            te1[3]  = rs(0, 0, 32'hDEAD55EF);
    tq1[4]  = rq(0, 32'h102, 2, 0);            te1[4]  = rs(0, 2, 32'h0000DEAD);
    tq1[5]  = rq(0, 32'h103, 0, 0);            te1[5]  = rs(0, 0, 32'h000000DE);
    tq1[6]  = rq(1, 32'h106, 3, 32'h00ABCDEF); te1[6]  = rs(1, 3, 0);
    tq1[7]  = rq(0, 32'h106, 2, 0);            te1[7]  = rs(0, 2, 32'h0000CDEF);
    tq1[8]  = rq(1, 32'h200, 0, 32'h11111111); te1[8]  = rs(1, 0, 0);
    tq1[9]  = rq(1, 32'h204, 0, 32'h22222222); te1[9]  = rs(1, 0, 0);
    tq1[10] = rq(1, 32'h208, 0, 32'h33333333); te1[10] = rs(1, 0, 0);
    tq1[11] = rq(1, 32'h20C, 0, 32'h44444444); te1[11] = rs(1, 0, 0);
    tq1[12] = rq(0, 32'h20D, 1, 0);            te1[12] = rs(0, 1, 32'h00000044);
    te4[0] = rs(0, 0, 32'h11111111);
    te4[1] = rs(0, 0, 32'h22222222);
    te4[2] = rs(0, 0, 32'h33333333);
    te4[3] = rs(0, 0, 32'h44444444);
    tq5[0] = rq(1, 32'h0, 0, 32'hA1A2A3A4);   te5[0] = rs(1, 0, 0);
    tq5[1] = rq(1, 32'h4, 0, 32'hB1B2B3B4);   te5[1] = rs(1, 0, 0);
    tq5[2] = rq(1, 32'h8, 0, 32'hC1C2C3C4);   te5[2] = rs(1, 0, 0);
    tq5[3] = rq(0, 32'h0, 0, 0);              te5[3] = rs(0, 0, 32'hA1A2A3A4);
    tq5[4] = rq(0, 32'h4, 0, 0);              te5[4] = rs(0, 0, 32'hB1B2B3B4);
    tq5[5] = rq(0, 32'h9, 1, 0);              te5[5] = rs(0, 1, 32'h000000C3);
    tq5[6] = rq(0, 32'h8, 2, 0);              te5[6] = rs(0, 2, 32'h0000C3C4);
  end

  initial begin
    int  idx, rx, last;
    bit  acc;

    // reset held with a pending request
    reset = 1'b0; req_val = 1'b1; req_msg = rq(1, 32'h300, 0, 32'h12345678); resp_rdy = 1'b1;
    req_val3 = 1'b0; req_msg3 = '0; resp_rdy3 = 1'b0;
    #1;
    chk_eq("t1_rdy_pre", 64'(req_rdy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_eq("t1_rdy_rst", 64'(req_rdy), 64'd0);
      chk_eq("t1_val_rst", 64'(resp_val), 64'd0);
    end
    chk_eq("t1_nreq", 64'(num_reqs), 64'd0);
    chk_eq("t1_nresp", 64'(num_resps), 64'd0);
    reset = 1'b1; req_val = 1'b0;
    #1;
    chk_eq("t1_rdy_rel", 64'(req_rdy), 64'd1);
    chk_eq("t1_val_rel", 64'(resp_val), 64'd0);
    cyc();

    // back-to-back table at latency 1: response k-1 visible while request k presented
    for (int k = 0; k <= N1; k++) begin
      if (k < N1) begin req_msg = tq1[k]; req_val = 1'b1; end
      else req_val = 1'b0;
      #1;
      if (k < N1) chk_eq($sformatf("t2_rdy_%0d", k), 64'(req_rdy), 64'd1);
      if (k > 0) begin
        chk_eq($sformatf("t2_val_%0d", k-1), 64'(resp_val), 64'd1);
        chk_eq($sformatf("t2_msg_%0d", k-1), 64'(resp_msg), 64'(te1[k-1]));
      end
      cyc();
    end
    chk_eq("t2_idle", 64'(resp_val), 64'd0);
    chk_eq("t2_nreq", 64'(num_reqs), 64'(N1));
    chk_eq("t2_nresp", 64'(num_resps), 64'(N1));

    // backpressure: only depth requests accepted while resp_rdy is low
    idx = 0; rx = 0;
    for (int c = 0; c < 5; c++) begin
      resp_rdy = 1'b0;
      if (idx < 4) begin req_msg = rq(0, 32'h200 + 32'(4*idx), 0, 0); req_val = 1'b1; end
      else req_val = 1'b0;
      #1;
      acc = req_val && req_rdy;
      cyc();
      if (acc) idx++;
    end
    chk_eq("t4_acc_bp", 64'(idx), 64'd2);
    #1;
    chk_eq("t4_rdy_full", 64'(req_rdy), 64'd0);
    chk_eq("t4_val_hold", 64'(resp_val), 64'd1);
    chk_eq("t4_msg_hold", 64'(resp_msg), 64'(te4[0]));
    for (int c = 0; c < 20 && rx < 4; c++) begin
      resp_rdy = 1'b1;
      if (idx < 4) begin req_msg = rq(0, 32'h200 + 32'(4*idx), 0, 0); req_val = 1'b1; end
      else req_val = 1'b0;
      #1;
      if (c == 0) chk_eq("t4_rdy_full_hs", 64'(req_rdy), 64'd1);
      acc = req_val && req_rdy;
      if (resp_val) begin
        chk_eq($sformatf("t4_msg_%0d", rx), 64'(resp_msg), 64'(te4[rx]));
        rx++;
      end
      cyc();
      if (acc) idx++;
    end
    req_val = 1'b0;
    chk_eq("t4_resp_cnt", 64'(rx), 64'd4);
    chk_eq("t4_acc_cnt", 64'(idx), 64'd4);
    chk_eq("t4_nreq", 64'(num_reqs), 64'(N1 + 4));
    chk_eq("t4_nresp", 64'(num_resps), 64'(N1 + 4));

    // reset with two responses queued
    resp_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_msg = rq(0, 32'h200 + 32'(4*k), 0, 0); req_val = 1'b1;
      #1;
      chk_eq($sformatf("t6_rdy_%0d", k), 64'(req_rdy), 64'd1);
      cyc();
    end
    req_val = 1'b0;
    #1;
    chk_eq("t6_val_queued", 64'(resp_val), 64'd1);
    reset = 1'b0;
    #1;
    chk_eq("t6_val_in_rst", 64'(resp_val), 64'd0);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk_eq("t6_val_rel", 64'(resp_val), 64'd0);
    chk_eq("t6_rdy_rel", 64'(req_rdy), 64'd1);
    chk_eq("t6_nreq_rel", 64'(num_reqs), 64'd0);
    chk_eq("t6_nresp_rel", 64'(num_resps), 64'd0);
    resp_rdy = 1'b1; req_msg = rq(0, 32'h100, 0, 0); req_val = 1'b1;
    cyc();
    req_val = 1'b0;
    #1;
    chk_eq("t6_val_after", 64'(resp_val), 64'd1);
    chk_eq("t6_msg_after", 64'(resp_msg), 64'(rs(0, 0, 32'hDEAD55EF)));
    cyc();
    chk_eq("t6_idle", 64'(resp_val), 64'd0);

    // latency 3, depth 3: one response per cycle, three cycles after each accept
    idx = 0; rx = 0; last = 0;
    for (int c = 0; c < 40 && rx < N5; c++) begin
      resp_rdy3 = 1'b1;
      if (idx < N5) begin req_msg3 = tq5[idx]; req_val3 = 1'b1; end
      else req_val3 = 1'b0;
      #1;
      if (idx < N5) chk_eq($sformatf("t5_rdy_%0d", idx), 64'(req_rdy3), 64'd1);
      acc = req_val3 && req_rdy3;
      if (acc) acc_c[idx] = ncyc;
      if (resp_val3) begin
        chk_eq($sformatf("t5_msg_%0d", rx), 64'(resp_msg3), 64'(te5[rx]));
        chk_eq($sformatf("t5_lat_%0d", rx), 64'(ncyc - acc_c[rx]), 64'd3);
        if (rx > 0) chk_eq($sformatf("t5_rate_%0d", rx), 64'(ncyc - last), 64'd1);
        last = ncyc;
        rx++;
      end
      cyc();
      if (acc) idx++;
    end
    req_val3 = 1'b0;
    chk_eq("t5_resp_cnt", 64'(rx), 64'(N5));
    chk_eq("t5_nreq", 64'(num_reqs3), 64'(N5));
    chk_eq("t5_nresp", 64'(num_resps3), 64'(N5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
